apb3_wait_slave_mem: RTL

//  APB3 slave memory model with programmable wait states and error injection.

---
 rtl/apb3_wait_slave_mem.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/apb3_wait_slave_mem.sv
// apb3_wait_slave_mem: APB3 slave memory model with programmable wait
// states, forced-error mode and a completed-transfer counter.
module apb3_wait_slave_mem #(
    parameter int DEPTH        = 256,
    parameter int DEFAULT_WAIT = 0,
    parameter int SEL_BIT      = 0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [15:0] PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CFG_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_W = (AW+1)'(DEPTH + 1);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [AW:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  cfg_wait_q, cfg_wait_d;
    logic        cfg_ferr_q, cfg_ferr_d;
    logic [15:0] acc_q, acc_d;
    logic [31:0] mem_q [DEPTH];

    logic        sel, ready, mem_we;
    logic [AW:0] widx;
    logic        s_mem, s_cfg, s_cnt;
    logic        q_mem, q_cfg;
    logic [31:0] cfg_rd, rd_val;
    logic        unused_bits;

    assign sel    = PSEL[SEL_BIT];
    assign widx   = PADDR[AW+2:2];
    assign s_mem  = ~widx[AW];
    assign s_cfg  = (widx == CFG_W);
    assign s_cnt  = (widx == CNT_W);
    assign q_mem  = ~addr_q[AW];
    assign q_cfg  = (addr_q == CFG_W);
    assign cfg_rd = {23'd0, cfg_ferr_q, 4'd0, cfg_wait_q};
    assign ready  = (state_q == ACCESS) && (wcnt_q == 4'd0);

    // High address bits alias; other select lines belong to other slaves.
    assign unused_bits = ^{PSEL, PADDR[31:AW+3]};

    // Read data captured at setup, from memory or a register.
    always_comb begin
        rd_val = 32'd0;
        if (s_mem)
            rd_val = mem_q[widx[AW-1:0]];
        else if (s_cfg)
            rd_val = cfg_rd;
        else if (s_cnt)
            rd_val = {16'd0, acc_q};
    end

    // Next-state logic: setup latch, wait countdown, completion, abort.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        cfg_wait_d = cfg_wait_q;
        cfg_ferr_d = cfg_ferr_q;
        acc_d      = acc_q;
        mem_we     = 1'b0;
        if (sel && !PENABLE) begin
            state_d = ACCESS;
            addr_d  = widx;
            write_d = PWRITE;
            wdata_d = PWDATA;
            rdata_d = rd_val;
            wcnt_d  = cfg_wait_q;
            err_d   = (PADDR[1:0] != 2'b00)
                    | ~(s_mem | s_cfg | s_cnt)
                    | (PWRITE & s_cnt)
                    | (s_mem & cfg_ferr_q);
        end else if (state_q == ACCESS) begin
            if (!sel) begin
                state_d = IDLE;
            end else if (ready) begin
                state_d = IDLE;
                if (!err_q) begin
                    acc_d  = acc_q + 16'd1;
                    mem_we = write_q & q_mem;
                    if (write_q && q_cfg) begin
                        cfg_wait_d = wdata_q[3:0];
                        cfg_ferr_d = wdata_q[8];
                    end
                end
            end else begin
                wcnt_d = wcnt_q - 4'd1;
            end
        end
    end

    // Control and register state with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            wcnt_q     <= 4'd0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            cfg_wait_q <= 4'(DEFAULT_WAIT);
            cfg_ferr_q <= 1'b0;
            acc_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            cfg_wait_q <= cfg_wait_d;
            cfg_ferr_q <= cfg_ferr_d;
            acc_q      <= acc_d;
        end
    end

    // Memory array: contents survive reset, pending write is dropped.
    always_ff @(posedge PCLK) begin
        if (!PRESET && mem_we)
            mem_q[addr_q[AW-1:0]] <= wdata_q;
    end

    assign PREADY  = ready;
    assign PRDATA  = (ready && !write_q && !err_q) ? rdata_q : 32'd0;
    assign PSLVERR = ready & err_q;

endmodule
